// File: rtl/async_fifo_rd_packer.sv
`default_nettype none
// ============================================================================
// Module   : async_fifo_rd_packer
// Brief    : Read-side consumer of async_fifo. Pops DATA_WIDTH words and
//            packs PACK_NUM of them into one valid/ready beat. A flush emits
//            any partial pack as a last beat.
// Revision : 1.0 - initial release
// ============================================================================
module async_fifo_rd_packer #(
   parameter  int DATA_WIDTH = 4,
   parameter  int PACK_NUM   = 4,
   localparam int CNT_WIDTH  = $clog2(PACK_NUM + 1)
) (
   input  logic                           rd_clk,
   input  logic                           rd_rst,
   input  logic                           fifo_empty,
   output logic                           fifo_rd_en,
   input  logic [DATA_WIDTH-1:0]          fifo_rd_data,
   input  logic                           flush,
   output logic                           flush_done,
   output logic                           m_valid,
   input  logic                           m_ready,
   output logic [DATA_WIDTH*PACK_NUM-1:0] m_data,
   output logic [CNT_WIDTH-1:0]           m_cnt,
   output logic                           m_last
);

   localparam int PACK_W = DATA_WIDTH * PACK_NUM;
   localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(PACK_NUM);

   localparam logic [1:0] ST_RUN  = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_EMIT = 2'd2;

   logic [1:0]           state;
   logic [CNT_WIDTH-1:0] cnt;    // words captured into the pack so far
   logic                 pend;   // a read was issued last cycle; data lands now
   logic [PACK_W-1:0]    pack;

   logic                 mv;     // full pack moves to the output register
   logic                 emit;   // partial pack moves out as a flush beat
   logic                 out_free;
   logic [CNT_WIDTH-1:0] cnt_plus_pend;

   assign out_free      = !m_valid || m_ready;
   assign mv            = (cnt == CNT_FULL) && out_free;
   assign emit          = (state == ST_EMIT) && out_free;
   assign cnt_plus_pend = cnt + {{(CNT_WIDTH-1){1'b0}}, pend};

   // Issue a read only while running and while the pack (including the word
   // in flight) still has room, or when the full pack is leaving this cycle.
   assign fifo_rd_en = !rd_rst && !fifo_empty && (state == ST_RUN) &&
                       ((cnt_plus_pend < CNT_FULL) || mv);

   // Pack assembly and output beat register.
   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         pend    <= 1'b0;
         cnt     <= '0;
         pack    <= '0;
         m_valid <= 1'b0;
         m_data  <= '0;
         m_cnt   <= '0;
         m_last  <= 1'b0;
      end else begin
         pend <= fifo_rd_en;
         // A full pack never has a word in flight, and no reads are issued
         // outside RUN, so a capture never coincides with mv or emit.
         if (mv) begin
            m_data  <= pack;
            m_cnt   <= CNT_FULL;
            m_last  <= 1'b0;
            m_valid <= 1'b1;
            cnt     <= '0;
            pack    <= '0;
         end else if (emit) begin
            m_data  <= pack;
            m_cnt   <= cnt;
            m_last  <= 1'b1;
            m_valid <= 1'b1;
            cnt     <= '0;
            pack    <= '0;
         end else begin
            if (m_ready) begin
               m_valid <= 1'b0;
            end
            if (pend) begin
               for (int i = 0; i < PACK_NUM; i++) begin
                  if (cnt == CNT_WIDTH'(i)) begin
                     pack[i*DATA_WIDTH +: DATA_WIDTH] <= fifo_rd_data;
                  end
               end
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

   // Flush sequencing: drain the in-flight read, then emit or finish.
   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         state      <= ST_RUN;
         flush_done <= 1'b0;
      end else begin
         flush_done <= 1'b0;
         case (state)
            ST_RUN: begin
               if (flush) begin
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // A full pack drains through the normal mv path first.
               if (!pend) begin
                  if (cnt == '0) begin
                     flush_done <= 1'b1;
                     state      <= ST_RUN;
                  end else if (cnt != CNT_FULL) begin
                     state <= ST_EMIT;
                  end
               end
            end
            ST_EMIT: begin
               if (emit) begin
                  flush_done <= 1'b1;
                  state      <= ST_RUN;
               end
            end
            default: state <= ST_RUN;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_async_fifo_rd_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_async_fifo_rd_packer
// Brief    : Directed self-checking bench for async_fifo_rd_packer with a
//            small behavioural FIFO (1-cycle read latency).
// Revision : 1.0 - initial release
// ============================================================================
module tb_async_fifo_rd_packer;

   localparam int DW = 4;
   localparam int PN = 4;

   logic          rd_clk = 1'b0;
   logic          rd_rst = 1'b1;
   logic          fifo_empty;
   logic          fifo_rd_en;
   logic [DW-1:0] fifo_rd_data = '0;
   logic          flush = 1'b0;
   logic          flush_done;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [15:0]   m_data;
   logic [2:0]    m_cnt;
   logic          m_last;

   logic [DW-1:0] mem [0:63];
   int            wr_cnt = 0;
   int            rd_cnt = 0;
   int            underflow = 0;
   int            errors = 0;
   int            checks = 0;
   int            fd_cnt = 0;
   int            mv_cnt = 0;
   int            base;

   async_fifo_rd_packer #(.DATA_WIDTH(DW), .PACK_NUM(PN)) dut (
      .rd_clk       (rd_clk),
      .rd_rst       (rd_rst),
      .fifo_empty   (fifo_empty),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_rd_data (fifo_rd_data),
      .flush        (flush),
      .flush_done   (flush_done),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .m_cnt        (m_cnt),
      .m_last       (m_last)
   );

   always #5 rd_clk = ~rd_clk;

   assign fifo_empty = (wr_cnt == rd_cnt);

   // Behavioural FIFO read port: data appears one cycle after rd_en.
   always @(posedge rd_clk) begin
      if (fifo_rd_en) begin
         if (wr_cnt == rd_cnt) begin
            underflow <= underflow + 1;
         end else begin
            fifo_rd_data <= mem[rd_cnt[5:0]];
            rd_cnt       <= rd_cnt + 1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [DW-1:0] w);
      mem[wr_cnt[5:0]] = w;
      wr_cnt = wr_cnt + 1;
   endtask

   task automatic tick();
      @(negedge rd_clk);
      fd_cnt += int'(flush_done);
      mv_cnt += int'(m_valid);
   endtask

   task automatic wait_valid(input string tag, input int max);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!m_valid && n < max);
      if (!m_valid) check({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      // Reset held for two cycles with data available in the FIFO.
      push(4'h1); push(4'h2); push(4'h3); push(4'h4);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
         check("rst_valid", 32'(m_valid), 32'd0);
         check("rst_fdone", 32'(flush_done), 32'd0);
      end
      check("rst_no_reads", 32'(rd_cnt), 32'd0);

      // One full pack with the sink always ready.
      rd_rst  = 1'b0;
      m_ready = 1'b1;
      base    = rd_cnt;
      wait_valid("t1", 20);
      check("t1_data", 32'(m_data), 32'h4321);
      check("t1_cnt", 32'(m_cnt), 32'd4);
      check("t1_last", 32'(m_last), 32'd0);
      check("t1_reads", 32'(rd_cnt - base), 32'd4);
      tick();
      check("t1_one_cycle", 32'(m_valid), 32'd0);

      // Backpressure: first beat held, second pack fills, reads stop.
      m_ready = 1'b0;
      base    = rd_cnt;
      for (int i = 0; i < 8; i++) push(4'(i));
      wait_valid("t2", 20);
      check("t2_first", 32'(m_data), 32'h3210);
      repeat (20) tick();
      check("t2_reads", 32'(rd_cnt - base), 32'd8);
      check("t2_rd_en_off", 32'(fifo_rd_en), 32'd0);
      check("t2_hold_data", 32'(m_data), 32'h3210);
      check("t2_hold_valid", 32'(m_valid), 32'd1);
      m_ready = 1'b1;
      tick();
      check("t2_second", 32'(m_data), 32'h7654);
      check("t2_second_valid", 32'(m_valid), 32'd1);
      tick();
      check("t2_drained", 32'(m_valid), 32'd0);

      // Partial pack emitted by a flush.
      push(4'hA); push(4'hB); push(4'hC);
      mv_cnt = 0;
      repeat (8) tick();
      check("t3_no_early_beat", 32'(mv_cnt), 32'd0);
      fd_cnt = 0;
      mv_cnt = 0;
      flush  = 1'b1;
      tick();
      flush  = 1'b0;
      wait_valid("t3", 10);
      check("t3_data", 32'(m_data), 32'h0CBA);
      check("t3_cnt", 32'(m_cnt), 32'd3);
      check("t3_last", 32'(m_last), 32'd1);
      repeat (4) tick();
      check("t3_fdone_once", 32'(fd_cnt), 32'd1);
      check("t3_one_beat", 32'(mv_cnt), 32'd1);

      // Flush with nothing buffered: done pulse, no beat, back to RUN.
      fd_cnt = 0;
      mv_cnt = 0;
      flush  = 1'b1;
      tick();
      flush  = 1'b0;
      repeat (4) tick();
      check("t4_fdone_once", 32'(fd_cnt), 32'd1);
      check("t4_no_beat", 32'(mv_cnt), 32'd0);
      push(4'h5); push(4'hA); push(4'hF); push(4'h0);
      wait_valid("t4_run", 20);
      check("t4_run_data", 32'(m_data), 32'h0FA5);
      check("t4_run_last", 32'(m_last), 32'd0);
      tick();

      // Reset with two words captured and one in flight.
      base = rd_cnt;
      push(4'h1); push(4'h2); push(4'h3);
      begin
         int n;
         n = 0;
         while ((rd_cnt - base) < 3 && n < 10) begin
            tick();
            n++;
         end
         check("t5_three_reads", 32'(rd_cnt - base), 32'd3);
      end
      rd_rst = 1'b1;
      tick();
      check("t5_valid", 32'(m_valid), 32'd0);
      check("t5_data", 32'(m_data), 32'd0);
      check("t5_cnt", 32'(m_cnt), 32'd0);
      check("t5_last", 32'(m_last), 32'd0);
      check("t5_fdone", 32'(flush_done), 32'd0);
      check("t5_rd_en", 32'(fifo_rd_en), 32'd0);
      rd_rst = 1'b0;
      push(4'h5); push(4'h6); push(4'h7); push(4'h8);
      wait_valid("t5_after", 20);
      check("t5_clean_data", 32'(m_data), 32'h8765);
      check("t5_clean_cnt", 32'(m_cnt), 32'd4);
      check("t5_clean_last", 32'(m_last), 32'd0);
      tick();

      check("no_underflow", 32'(underflow), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
